// File: rtl/dac7821_pkg.sv
// Shared definitions for the DAC7821 write sequencer: data width, counter
// width, default strobe timing and the sequencer state encoding.
package dac7821_pkg;

  localparam int DAC_W = 12;
  localparam int CNT_W = 8;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_t;

  // Counter load value for a phase lasting 'cycles' clocks (the counter
  // runs down to zero, so the last cycle of the phase is the zero cycle).
  function automatic logic [CNT_W-1:0] cyc_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dac7821_write_sched_rr_arb2.sv
// Two-request round-robin arbiter. A lone request wins outright; when both
// sources request, the one that did not win the previous grant wins.
// Priority only moves when the caller strobes 'update' on an actual grant.
module rr_arb2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_b;

  // One-hot grant from the current requests and the priority pointer
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_b ? 2'b10 : 2'b01;
    end
  end

  // After A is granted B gets the next contested slot, and vice versa
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prio_b <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio_b <= grant[0];
    end
  end

endmodule

// File: rtl/dac7821_write_sched.sv
// DAC7821 write sequencer: arbitrates between two waveform sources, latches
// the granted word onto the DAC data bus and produces the CS_n/RW_n write
// strobe with programmable setup, strobe and hold phases.
module dac7821_write_sched
  import dac7821_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [DAC_W-1:0] DinA,
  output logic             AckA,
  input  logic             ReqB,
  input  logic [DAC_W-1:0] DinB,
  output logic             AckB,
  output logic [DAC_W-1:0] Dout,
  output logic             CS_n,
  output logic             RW_n,
  output logic             Busy,
  output logic             GrantB
);

  localparam logic [CNT_W-1:0] SETUP_LD  = cyc_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = cyc_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = cyc_load(HOLD_CYC);

  wr_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             grant_now;

  assign req       = {ReqB, ReqA};
  assign grant_now = (state == ST_IDLE) && (req != 2'b00);
  assign Busy      = (state != ST_IDLE);

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (req),
    .update (grant_now),
    .grant  (grant)
  );

  // Sequencer: every pin-level output comes straight from a flop so the DAC
  // never sees a combinational glitch on its strobes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      Dout   <= '0;
      GrantB <= 1'b0;
      AckA   <= 1'b0;
      AckB   <= 1'b0;
      CS_n   <= 1'b1;
      RW_n   <= 1'b1;
    end else begin
      AckA <= 1'b0;
      AckB <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            Dout   <= grant[1] ? DinB : DinA;
            GrantB <= grant[1];
            AckA   <= grant[0];
            AckB   <= grant[1];
            RW_n   <= 1'b0;
            cnt    <= SETUP_LD;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            CS_n  <= 1'b0;
            cnt   <= STROBE_LD;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            CS_n  <= 1'b1;
            cnt   <= HOLD_LD;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            RW_n  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          CS_n  <= 1'b1;
          RW_n  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac7821_write_sched.sv
// Self-checking bench for dac7821_write_sched. Instance 1 uses default timing
// and is checked cycle by cycle by a transaction-level scoreboard; instance 2
// uses stretched timing (3/1/4) and is checked with a directed waveform.
module tb_dac7821_write_sched;

  localparam int S1 = 1, ST1 = 2, H1 = 1;
  localparam int TOTAL1 = S1 + ST1 + H1;
  localparam int S2 = 3, ST2 = 1, H2 = 4;
  localparam int TOTAL2 = S2 + ST2 + H2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqA = 1'b0, ReqB = 1'b0;
  logic [11:0] DinA = '0, DinB = '0;
  logic        AckA, AckB, CS_n, RW_n, Busy, GrantB;
  logic [11:0] Dout;

  logic        ReqA2 = 1'b0;
  logic [11:0] DinA2 = '0;
  logic        ReqB2 = 1'b0;
  logic [11:0] DinB2 = '0;
  logic        AckA2, AckB2, CS_n2, RW_n2, Busy2, GrantB2;
  logic [11:0] Dout2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          b;
    logic [11:0] data;
    int          ackCyc;
  } exp_t;

  exp_t q[$];
  bit   logB[$];
  int   logCyc[$];

  int   cyc = 0;
  int   nextFree = 0;
  bit   lastB = 1'b1;
  bit   win;
  bit   rstEdge = 1'b0;

  bit          monOn = 1'b0;
  bit          curValid = 1'b0;
  bit          curB = 1'b0;
  logic [11:0] curData = '0;
  int          curAck = 0;

  always #5 Clock = ~Clock;

  dac7821_write_sched #(.SETUP_CYC(S1), .STROBE_CYC(ST1), .HOLD_CYC(H1)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .DinA(DinA), .AckA(AckA),
    .ReqB(ReqB), .DinB(DinB), .AckB(AckB),
    .Dout(Dout), .CS_n(CS_n), .RW_n(RW_n), .Busy(Busy), .GrantB(GrantB)
  );

  dac7821_write_sched #(.SETUP_CYC(S2), .STROBE_CYC(ST2), .HOLD_CYC(H2)) dut2 (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA2), .DinA(DinA2), .AckA(AckA2),
    .ReqB(ReqB2), .DinB(DinB2), .AckB(AckB2),
    .Dout(Dout2), .CS_n(CS_n2), .RW_n(RW_n2), .Busy(Busy2), .GrantB(GrantB2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: transaction level. The channel is free again
  // 1 + SETUP + STROBE + HOLD edges after a grant; contested grants go to
  // whichever source did not win last time.
  always @(posedge Clock) begin
    rstEdge = Reset;
    if (Reset) begin
      q.delete();
      lastB    = 1'b1;
      nextFree = cyc + 1;
    end else if (cyc >= nextFree && (ReqA || ReqB)) begin
      win = (ReqA && ReqB) ? !lastB : ReqB;
      q.push_back('{win, win ? DinB : DinA, cyc + 1});
      lastB    = win;
      nextFree = cyc + 1 + TOTAL1;
    end
    cyc <= cyc + 1;
  end

  // Monitor: pops the expected write when its ack cycle arrives and checks
  // every pin of instance 1 against the ideal write waveform
  always @(negedge Clock) begin
    bit expA, expB, inWin;
    int k;
    exp_t e;
    if (rstEdge) begin
      monOn = 1'b1; curValid = 1'b0; curData = '0; curB = 1'b0;
    end
    if (monOn) begin
      expA = 1'b0; expB = 1'b0;
      if (q.size() > 0 && q[0].ackCyc == cyc) begin
        e = q.pop_front();
        expA = !e.b; expB = e.b;
        curValid = 1'b1; curB = e.b; curData = e.data; curAck = cyc;
      end
      if (AckA === 1'b1 || AckB === 1'b1) begin
        logB.push_back(AckB === 1'b1);
        logCyc.push_back(cyc);
      end
      k = cyc - curAck;
      inWin = curValid && (k < TOTAL1);
      checkOutput("sb_AckA", AckA, expA);
      checkOutput("sb_AckB", AckB, expB);
      checkOutput("sb_Dout", Dout, curData);
      checkOutput("sb_GrantB", GrantB, curB);
      checkOutput("sb_Busy", Busy, inWin);
      checkOutput("sb_RW_n", RW_n, !inWin);
      checkOutput("sb_CS_n", CS_n, !(inWin && k >= S1 && k < S1 + ST1));
    end
  end

  task automatic resetDut(input int n);
    @(negedge Clock);
    Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
    repeat (n) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic waitAck(input bit b, input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge Clock);
      if ((b ? AckB : AckA) === 1'b1) got = 1'b1;
    end
    checkOutput(b ? "ackB_seen" : "ackA_seen", got, 1);
    if (b) ReqB = 1'b0; else ReqA = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int i = 0;
    while (Busy !== 1'b0 && i < limit) begin
      @(negedge Clock);
      i++;
    end
    checkOutput("idle_reached", Busy, 0);
  endtask

  task automatic applyStimulus();
    int n;
    bit got;
    // reset values
    resetDut(3);
    checkOutput("rst_Dout", Dout, 12'h000);
    checkOutput("rst_CS_n", CS_n, 1);
    checkOutput("rst_RW_n", RW_n, 1);
    checkOutput("rst_Busy", Busy, 0);
    checkOutput("rst_AckA", AckA, 0);
    checkOutput("rst_AckB", AckB, 0);
    checkOutput("rst_GrantB", GrantB, 0);

    // single write from A
    ReqA = 1'b1; DinA = 12'hABC;
    waitAck(1'b0, 10);
    checkOutput("a_Dout", Dout, 12'hABC);
    n = 1;
    for (int i = 0; i < 20 && Busy === 1'b1; i++) begin
      @(negedge Clock);
      if (Busy === 1'b1) n++;
    end
    checkOutput("a_busy_len", n, TOTAL1);

    // B alone after reset, then a contested grant goes to A
    resetDut(2);
    ReqB = 1'b1; DinB = 12'h3C3;
    waitAck(1'b1, 10);
    waitIdle(20);
    ReqA = 1'b1; DinA = 12'h0A5; ReqB = 1'b1; DinB = 12'h5A0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clock);
      if (AckA === 1'b1 || AckB === 1'b1) got = 1'b1;
    end
    checkOutput("contest_AckA", AckA, 1);
    checkOutput("contest_AckB", AckB, 0);
    ReqA = 1'b0;
    waitAck(1'b1, 20);
    waitIdle(20);

    // both held continuously: A,B,A,B at one write every 5 cycles
    logB.delete(); logCyc.delete();
    ReqA = 1'b1; DinA = 12'h111; ReqB = 1'b1; DinB = 12'h222;
    repeat (21) @(negedge Clock);
    ReqA = 1'b0; ReqB = 1'b0;
    checkOutput("alt_count_ge4", logB.size() >= 4, 1);
    if (logB.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("alt_src", logB[i], i % 2);
      for (int i = 1; i < 4; i++) checkOutput("alt_period", logCyc[i] - logCyc[i-1], TOTAL1 + 1);
    end
    waitIdle(20);

    // reset in the middle of the strobe
    ReqA = 1'b1; DinA = 12'h777;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (AckA === 1'b1) ReqA = 1'b0;
      if (CS_n === 1'b0) got = 1'b1;
    end
    checkOutput("strobe_reached", got, 1);
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("midrst_CS_n", CS_n, 1);
    checkOutput("midrst_Busy", Busy, 0);
    checkOutput("midrst_RW_n", RW_n, 1);
    checkOutput("midrst_Dout", Dout, 12'h000);
    Reset = 1'b0; ReqA = 1'b0;

    // randomized traffic, data on idle sources scrambled every cycle
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (AckA === 1'b1) ReqA = 1'b0;
      else if (!ReqA) begin
        DinA = 12'($urandom);
        if ($urandom_range(0, 3) == 0) ReqA = 1'b1;
      end
      if (AckB === 1'b1) ReqB = 1'b0;
      else if (!ReqB) begin
        DinB = 12'($urandom);
        if ($urandom_range(0, 3) == 0) ReqB = 1'b1;
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    waitIdle(20);
    repeat (2) @(negedge Clock);
    checkOutput("sb_empty", q.size(), 0);
  endtask

  task automatic checkOutput2();
    bit got = 1'b0;
    ReqA2 = 1'b1; DinA2 = 12'h5A5;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clock);
      if (AckA2 === 1'b1) got = 1'b1;
    end
    checkOutput("t2_ack_seen", got, 1);
    ReqA2 = 1'b0;
    for (int k = 0; k < TOTAL2 + 2; k++) begin
      checkOutput("t2_AckA", AckA2, k == 0);
      checkOutput("t2_Dout", Dout2, 12'h5A5);
      checkOutput("t2_Busy", Busy2, k < TOTAL2);
      checkOutput("t2_RW_n", RW_n2, k >= TOTAL2);
      checkOutput("t2_CS_n", CS_n2, !(k >= S2 && k < S2 + ST2));
      @(negedge Clock);
    end
  endtask

  initial begin
    applyStimulus();
    checkOutput2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dac7821_write_sched.md
# dac7821_write_sched

Write sequencer and two-port arbiter for the 12-bit parallel DAC7821 channel. Accepts samples from two waveform sources (A = carrier path, B = modulation-wave path), grants the DAC round-robin, holds the granted word on the DAC data bus and generates the CS_n/RW_n write strobes with programmable setup, strobe and hold widths. It sits between the waveform generators and the DAC7821 pins, replacing direct register-enable writes.

## Interface
Parameters:
- SETUP_CYC, 1, cycles Dout is stable with RW_n low before CS_n falls (range 1..255)
- STROBE_CYC, 2, cycles CS_n is held low (range 1..255)
- HOLD_CYC, 1, cycles Dout and RW_n are held after CS_n rises (range 1..255)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- ReqA  in  1  source A has a sample on DinA (level, held until AckA)
- DinA  in  12  source A sample
- AckA  out  1  one-cycle pulse: DinA captured
- ReqB  in  1  source B request (same rules as A)
- DinB  in  12  source B sample
- AckB  out  1  one-cycle pulse: DinB captured
- Dout  out  12  DAC7821 DB[11:0]
- CS_n  out  1  DAC chip select, active low
- RW_n  out  1  DAC read/write, low = write
- Busy  out  1  high whenever state is not IDLE
- GrantB  out  1  source of the word currently on Dout (0 = A, 1 = B)

## Operation
- States: IDLE, SETUP, STROBE, HOLD. Down-counter (8 bit) times each non-IDLE state.
- IDLE: if ReqA or ReqB sampled high, arbiter picks winner; next edge: Dout <= winner's Din, GrantB <= winner, Ack of winner <= 1, RW_n <= 0, state <= SETUP, counter <= SETUP_CYC-1. No request: remain IDLE, outputs unchanged.
- Arbitration: single request wins outright. Both high: the source not granted last time wins. Priority pointer updates only on a grant; after reset A has priority.
- SETUP: CS_n=1, RW_n=0. When counter==0 -> STROBE, counter <= STROBE_CYC-1, CS_n <= 0.
- STROBE: CS_n=0. When counter==0 -> HOLD, counter <= HOLD_CYC-1, CS_n <= 1 (DAC latches on this rising CS_n).
- HOLD: CS_n=1, RW_n=0, Dout held. When counter==0 -> IDLE, RW_n <= 1.
- Dout and GrantB change only on a grant edge; held through IDLE afterwards.
- Ack pulses are registered, exactly one cycle, coincident with the first SETUP cycle. Requests are sampled only in IDLE; a Req still high at the next IDLE is treated as a new sample.
- Reset (any state, including mid-strobe): next edge state=IDLE, CS_n=1, RW_n=1, Dout=0, AckA=AckB=0, Busy=0, GrantB=0, priority to A, counter=0. An interrupted write is not retried.

## Timing
- Grant-decision cycle (IDLE) to first SETUP cycle: 1 edge.
- Write occupies SETUP_CYC + STROBE_CYC + HOLD_CYC cycles with Busy high; IDLE always lasts at least 1 cycle between writes.
- Max sample rate: one write per 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles (defaults: 5).
- CS_n low width exactly STROBE_CYC cycles; Dout stable from SETUP_CYC cycles before CS_n falls until HOLD_CYC cycles after CS_n rises.
- CS_n and RW_n are driven directly from flops (glitch-free).

## Structure
- Package dac7821_pkg: DAC_W = 12, state enum (IDLE, SETUP, STROBE, HOLD), default SETUP/STROBE/HOLD constants, counter width 8.
- Sub-module rr_arb2: two-request round-robin arbiter (req[1:0], update strobe -> one-hot grant, priority flop inside). Sequencer FSM and counter stay in the top module.

## Test plan
- Reset -> Dout=0x000, CS_n=1, RW_n=1, Busy=0, Acks 0; assert Reset during STROBE -> CS_n=1 and state IDLE after next edge.
- ReqA only, DinA=0xABC, defaults -> AckA one cycle, Dout=0xABC, CS_n low exactly 2 cycles starting 1 cycle after AckA, Busy high 4 cycles.
- ReqA and ReqB held high continuously, DinA=0x111, DinB=0x222 -> writes alternate A,B,A,B starting with A; one write every 5 cycles.
- ReqB only after reset, then both -> B first, then A wins the contested grant.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=4 -> Dout stable 3 cycles before CS_n falls, CS_n low 1 cycle, RW_n returns high 4 cycles after CS_n rises.
- DinA changed while Busy -> Dout unchanged until the next grant.
